lc3_operate_ctrl: RTL

Multi-cycle sequencer for LC-3 operate instructions (ADD, AND, NOT) around the shared ALU. Accepts an instruction word via valid/ready and reads operands from the external register file. Drives ALUK/A/B to the ALU, writes the result back, and updates the NZP condition codes. Sits between the fetch/decode front end and the ALU + register file.

---
 rtl/lc3_pkg.sv | 33 +++
 rtl/lc3_sext.sv | 14 +
 rtl/lc3_operate_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/lc3_pkg.sv
// lc3_pkg: shared constants for the LC-3 operate-instruction sequencer.
//   Opcodes (IR[15:12]), ALUK encodings, NZP constants, controller state
//   encoding and a helper that derives NZP from a 16-bit result.
package lc3_pkg;

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [2:0] NZP_N = 3'b100;
  localparam logic [2:0] NZP_Z = 3'b010;
  localparam logic [2:0] NZP_P = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_DECODE    = 2'b01,
    ST_EXECUTE   = 2'b10,
    ST_WRITEBACK = 2'b11
  } state_t;

  // Exactly one bit set: sign first, then zero, else positive.
  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v[15])          return NZP_N;
    else if (v == 16'h0) return NZP_Z;
    else                return NZP_P;
  endfunction

endpackage

// File: rtl/lc3_sext.sv
// lc3_sext: combinational sign extension of a W_IN-bit field to W_OUT bits.
//   i_val : W_IN-bit two's-complement field (imm5, offset6/9/11)
//   o_val : W_OUT-bit sign-extended value
module lc3_sext #(
  parameter int W_IN  = 5,
  parameter int W_OUT = 16
) (
  input  logic [W_IN-1:0]  i_val,
  output logic [W_OUT-1:0] o_val
);

  assign o_val = {{(W_OUT-W_IN){i_val[W_IN-1]}}, i_val};

endmodule

// File: rtl/lc3_operate_ctrl.sv
// lc3_operate_ctrl: four-state sequencer for LC-3 ADD/AND/NOT.
//   CLK, RESET          : clock, synchronous active-high reset
//   IR_VALID/IR/IR_READY: instruction handshake (accepted only in IDLE)
//   SR1/SR2, *_DATA     : register-file read ports (combinational data)
//   ALUK/ALU_A/ALU_B    : ALU controls/operands, ALU_OUT result back
//   DR/DR_WE/DR_DATA    : register-file write-back (one cycle)
//   NZP                 : condition codes, updated on write-back
//   DONE/ILLEGAL        : one-cycle retire / reject pulses
module lc3_operate_ctrl
  import lc3_pkg::*;
#(
  parameter bit         STRICT_NOT = 1'b1,
  parameter logic [2:0] NZP_RESET  = 3'b010
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IR_VALID,
  input  logic [15:0] IR,
  output logic        IR_READY,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  input  logic [15:0] SR1_DATA,
  input  logic [15:0] SR2_DATA,
  output logic [1:0]  ALUK,
  output logic [15:0] ALU_A,
  output logic [15:0] ALU_B,
  input  logic [15:0] ALU_OUT,
  output logic [2:0]  DR,
  output logic        DR_WE,
  output logic [15:0] DR_DATA,
  output logic [2:0]  NZP,
  output logic        DONE,
  output logic        ILLEGAL
);

  state_t      r_state, w_next;
  logic [15:0] r_ir, r_opa, r_opb, r_res;
  logic [2:0]  r_nzp;

  logic [3:0]  w_opcode;
  logic        w_legal, w_illegal, w_accept;
  logic [15:0] w_imm5, w_opb;
  logic [1:0]  w_aluk;

  assign w_opcode = r_ir[15:12];

  lc3_sext #(.W_IN(5), .W_OUT(16)) u_sext (
    .i_val (r_ir[4:0]),
    .o_val (w_imm5)
  );

  always_comb begin
    w_legal = 1'b0;
    w_aluk  = ALUK_NOT;
    case (w_opcode)
      OP_ADD: begin w_legal = 1'b1; w_aluk = ALUK_ADD; end
      OP_AND: begin w_legal = 1'b1; w_aluk = ALUK_AND; end
      OP_NOT: begin
        w_legal = !STRICT_NOT || (r_ir[5:0] == 6'h3F);
        w_aluk  = ALUK_NOT;
      end
      default: ;
    endcase
  end

  // NOT ignores operand B; capture a clean 0 rather than whatever SR2 reads.
  assign w_opb = (w_opcode == OP_NOT) ? 16'h0 :
                 r_ir[5]              ? w_imm5 : SR2_DATA;

  assign w_accept = IR_VALID && IR_READY;

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      ST_IDLE:      if (w_accept) w_next = ST_DECODE;
      ST_DECODE: begin
        if (!w_legal) begin
          w_illegal = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_next    = ST_EXECUTE;
        end
      end
      ST_EXECUTE:   w_next = ST_WRITEBACK;
      ST_WRITEBACK: w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_ir    <= '0;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_nzp   <= NZP_RESET;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE:      if (w_accept) r_ir <= IR;
        ST_DECODE: begin
          if (w_legal) begin
            r_opa <= SR1_DATA;
            r_opb <= w_opb;
          end
        end
        ST_EXECUTE:   r_res <= ALU_OUT;
        ST_WRITEBACK: r_nzp <= nzp_of(r_res);
        default: ;
      endcase
    end
  end

  // Strobes are masked by RESET so an aborted instruction cannot write
  // on the same edge that resets the controller.
  assign IR_READY = (r_state == ST_IDLE) && !RESET;
  assign ILLEGAL  = w_illegal && !RESET;
  assign DR_WE    = (r_state == ST_WRITEBACK) && !RESET;
  assign DONE     = DR_WE;
  assign ALUK     = (r_state == ST_EXECUTE && !RESET) ? w_aluk : ALUK_PASSA;

  // Operand registers only change at the end of DECODE, so they naturally
  // hold their last value outside EXECUTE.
  assign ALU_A    = r_opa;
  assign ALU_B    = r_opb;
  assign SR1      = r_ir[8:6];
  assign SR2      = r_ir[2:0];
  assign DR       = r_ir[11:9];
  assign DR_DATA  = r_res;
  assign NZP      = r_nzp;

endmodule
